// File: rtl/ysyx_23060240_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, fixed
// instruction/address constants and the inst_err encodings.
package ysyx_23060240_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } ifu_state_e;

    localparam logic [31:0] RESET_PC     = 32'h8000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [1:0]  ERR_OK       = 2'b00;
    localparam logic [1:0]  ERR_ACCESS   = 2'b01;
    localparam logic [1:0]  ERR_MISALIGN = 2'b10;

    function automatic logic is_misaligned(input logic [1:0] pc_lsb);
        return pc_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060240_ifu_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched entries; clear wins over push/pop.
module ysyx_23060240_ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 66
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;

    // Storage, pointers and occupancy; storage is zeroed on reset so head reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/ysyx_23060240_ifu.sv
// Instruction fetch unit: one outstanding memory read per pc, fetched
// {pc, inst, err} buffered for decode; flush_i discards queued and in-flight fetches.
module ysyx_23060240_ifu
    import ysyx_23060240_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_adv_o,
    input  logic            flush_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            resp_valid_i,
    input  logic [XLEN-1:0] resp_data_i,
    input  logic            resp_err_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic [1:0]      inst_err_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 2 * XLEN + 2;

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic            misaligned_s;
    logic            space_s;
    logic            req_fire_s;
    logic            mis_push_s;
    logic            resp_push_s;
    logic            push_s;
    logic            pop_s;
    logic [EW-1:0]   push_data_s;
    logic [EW-1:0]   head_s;
    logic [CW-1:0]   count_s;
    logic            empty_s;

    // Issue, push/pop and next-state decisions; flush suppresses every side effect.
    always_comb begin
        misaligned_s = is_misaligned(pc_i[1:0]);
        // Outstanding is zero in S_REQ, so occupancy alone gates issue.
        space_s      = (count_s < CW'(DEPTH));
        req_valid_o  = (state_q == S_REQ) & space_s & ~flush_i & ~misaligned_s;
        mis_push_s   = (state_q == S_REQ) & space_s & ~flush_i & misaligned_s;
        req_fire_s   = req_valid_o & req_ready_i;
        pc_adv_o     = req_fire_s | mis_push_s;
        resp_push_s  = (state_q == S_WAIT) & resp_valid_i & ~flush_i;
        push_s       = resp_push_s | mis_push_s;
        pop_s        = inst_valid_o & inst_ready_i & ~flush_i;
        if (mis_push_s) begin
            push_data_s = {pc_i, XLEN'(NOP_INST), ERR_MISALIGN};
        end else begin
            push_data_s = {req_pc_q, resp_data_i, (resp_err_i ? ERR_ACCESS : ERR_OK)};
        end
        req_pc_d = req_fire_s ? pc_i : req_pc_q;
        state_d  = state_q;
        case (state_q)
            S_REQ: begin
                if (req_fire_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (resp_valid_i) begin
                    state_d = S_REQ;
                end else if (flush_i) begin
                    state_d = S_DROP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DROP: begin
                if (resp_valid_i) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // FSM state and the pc of the request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            req_pc_q <= XLEN'(RESET_PC);
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    ysyx_23060240_ifu_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(EW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push_s),
        .pop_i  (pop_s),
        .clear_i(flush_i),
        .data_i (push_data_s),
        .head_o (head_s),
        .count_o(count_s),
        .empty_o(empty_s)
    );

    assign req_addr_o   = pc_i;
    assign inst_valid_o = ~empty_s;
    assign inst_pc_o    = head_s[EW-1 -: XLEN];
    assign inst_o       = head_s[XLEN+1 -: XLEN];
    assign inst_err_o   = head_s[1:0];

endmodule

// File: tb/tb_ysyx_23060240_ifu.sv
// Bench for the fetch unit: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a queue-based model.
module tb_ysyx_23060240_ifu;
    localparam int DEPTH = 2;

    logic        clk, rst, flush_i, req_ready_i, resp_valid_i, resp_err_i, inst_ready_i;
    logic [31:0] pc_i, resp_data_i;
    logic        pc_adv_o, req_valid_o, inst_valid_o;
    logic [31:0] req_addr_o, inst_o, inst_pc_o;
    logic [1:0]  inst_err_o;

    ysyx_23060240_ifu #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_adv_o(pc_adv_o), .flush_i(flush_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_addr_o(req_addr_o),
        .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i), .resp_err_i(resp_err_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
        .inst_pc_o(inst_pc_o), .inst_err_o(inst_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  err;
    } ent_t;

    // Model: decode queue plus "waiting for a keeper" / "waiting for a discard" flags.
    ent_t        mq[$];
    bit          m_wait, m_drop, mem_pend;
    logic [31:0] m_pc;
    bit          e_adv, e_rv;
    int          n_pass, n_total, cyc;

    logic        obs_rv, obs_adv, obs_iv;
    logic [31:0] obs_addr, obs_inst, obs_ipc;
    logic [1:0]  obs_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic drive(input bit r, input bit fl, input bit rdy, input bit rv,
                         input logic [31:0] pc, input logic [31:0] data,
                         input bit er, input bit ir);
        rst = r; flush_i = fl; req_ready_i = rdy; resp_valid_i = rv;
        pc_i = pc; resp_data_i = data; resp_err_i = er; inst_ready_i = ir;
    endtask

    // One cycle: sample at the falling edge, compare with the model, advance the model.
    task automatic step();
        bit   idle, space, mis;
        ent_t e;
        #4;
        obs_rv = req_valid_o; obs_adv = pc_adv_o; obs_iv = inst_valid_o;
        obs_addr = req_addr_o; obs_inst = inst_o; obs_ipc = inst_pc_o; obs_err = inst_err_o;
        if (rst) begin
            mq.delete();
            m_wait = 1'b0; m_drop = 1'b0; mem_pend = 1'b0; e_adv = 1'b0; e_rv = 1'b0;
        end else begin
            idle  = !m_wait && !m_drop;
            space = mq.size() < DEPTH;
            mis   = pc_i[1:0] != 2'b00;
            e_rv  = idle && space && !flush_i && !mis;
            e_adv = idle && space && !flush_i && (mis || req_ready_i);
            chk("req_valid", 32'(req_valid_o), 32'(e_rv));
            chk("pc_adv", 32'(pc_adv_o), 32'(e_adv));
            chk("inst_valid", 32'(inst_valid_o), 32'(mq.size() != 0));
            if (e_rv) chk("req_addr", req_addr_o, pc_i);
            if (mq.size() != 0) begin
                chk("inst", inst_o, mq[0].inst);
                chk("inst_pc", inst_pc_o, mq[0].pc);
                chk("inst_err", 32'(inst_err_o), 32'(mq[0].err));
            end
            if (resp_valid_i) mem_pend = 1'b0;
            if (e_rv && req_ready_i) mem_pend = 1'b1;
            if (flush_i) begin
                mq.delete();
                if (m_wait) begin
                    m_drop = !resp_valid_i;
                    m_wait = 1'b0;
                end else if (m_drop && resp_valid_i) begin
                    m_drop = 1'b0;
                end
            end else begin
                if (mq.size() != 0 && inst_ready_i) void'(mq.pop_front());
                if (m_wait && resp_valid_i) begin
                    e = '{m_pc, resp_data_i, (resp_err_i ? 2'b01 : 2'b00)};
                    mq.push_back(e);
                    m_wait = 1'b0;
                end else if (m_drop && resp_valid_i) begin
                    m_drop = 1'b0;
                end
                if (e_adv) begin
                    if (mis) begin
                        e = '{pc_i, 32'h0000_0013, 2'b10};
                        mq.push_back(e);
                    end else begin
                        m_wait = 1'b1;
                        m_pc   = pc_i;
                    end
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tgt;
        n_pass = 0; n_total = 0; cyc = 0;
        m_wait = 1'b0; m_drop = 1'b0; mem_pend = 1'b0; m_pc = 32'h0;
        tgt = 32'h8000_0000;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step();

        // Basic fetch after reset; reset-state outputs are zero.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 1'b0); step();
        chk("t1_req_valid", 32'(obs_rv), 32'd1);
        chk("t1_adv", 32'(obs_adv), 32'd1);
        chk("rst_inst_valid", 32'(obs_iv), 32'd0);
        chk("rst_inst_o", obs_inst, 32'h0);
        chk("rst_inst_pc", obs_ipc, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0004, 32'h0010_0093, 1'b0, 1'b0); step();
        chk("t1_wait_adv", 32'(obs_adv), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 1'b0); step();
        chk("t1_inst_valid", 32'(obs_iv), 32'd1);
        chk("t1_inst", obs_inst, 32'h0010_0093);
        chk("t1_inst_pc", obs_ipc, 32'h8000_0000);
        chk("t1_err", 32'(obs_err), 32'd0);

        // Decode stalled: queue fills to DEPTH and issue stops; order kept on release.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0008, 32'h0020_0113, 1'b0, 1'b0); step();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 1'b0, 1'b0); step();
        chk("t2_full_req_valid", 32'(obs_rv), 32'd0);
        chk("t2_full_adv", 32'(obs_adv), 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 1'b0, 1'b1); step();
        chk("t2_first_pc", obs_ipc, 32'h8000_0000);
        step();
        chk("t2_second_pc", obs_ipc, 32'h8000_0004);
        chk("t2_second_inst", obs_inst, 32'h0020_0113);

        // Flush while waiting: late response dropped, next fetch from the jump target.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_000c, 32'h0, 1'b0, 1'b0); step();
        chk("t3_flush_rv", 32'(obs_rv), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 1'b0, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0100, 32'h0, 1'b0, 1'b0); step();
        chk("t3_queue_empty", 32'(obs_iv), 32'd0);
        chk("t3_req_addr", obs_addr, 32'h8000_0100);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 1'b0, 1'b0); step();

        // Flush coincident with response and ready: nothing pushed, nothing issued.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0104, 32'h1111_1111, 1'b0, 1'b0); step();
        chk("t4_rv", 32'(obs_rv), 32'd0);
        chk("t4_adv", 32'(obs_adv), 32'd0);

        // Misaligned pc: no memory request, NOP entry with err 10.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0002, 32'h0, 1'b0, 1'b0); step();
        chk("t5_rv", 32'(obs_rv), 32'd0);
        chk("t5_adv", 32'(obs_adv), 32'd1);
        chk("t4_nothing_pushed", 32'(obs_iv), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0006, 32'h0, 1'b0, 1'b0); step();
        chk("t5_inst_pc", obs_ipc, 32'h8000_0002);
        chk("t5_inst", obs_inst, 32'h0000_0013);
        chk("t5_err", 32'(obs_err), 32'd2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_000a, 32'h0, 1'b0, 1'b0); step();

        // Access fault marks err 01; reset in mid-wait ignores the late response.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0008, 32'h0, 1'b0, 1'b1); step();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_000c, 32'h0, 1'b1, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_000c, 32'h0, 1'b0, 1'b0); step();
        chk("t6_err_pc", obs_ipc, 32'h8000_0008);
        chk("t6_err", 32'(obs_err), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_000c, 32'h0, 1'b0, 1'b0); step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b0, 1'b0); step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h5555_5555, 1'b0, 1'b0); step();
        chk("t6_rst_rv", 32'(obs_rv), 32'd1);
        chk("t6_rst_iv", 32'(obs_iv), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 1'b0); step();
        chk("t6_late_ignored", 32'(obs_iv), 32'd0);

        // Randomized traffic; the bench plays the PC register and the memory.
        for (int i = 0; i < 4000; i++) begin
            if (rst) pc_i = 32'h8000_0000;
            else if (flush_i) pc_i = tgt;
            else if (e_adv) pc_i = pc_i + 32'd4;
            rst          = ($urandom_range(0, 499) == 0);
            flush_i      = !rst && ($urandom_range(0, 19) == 0);
            tgt          = 32'h8000_0000 + ($urandom_range(0, 255) << 2)
                           + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
            req_ready_i  = ($urandom_range(0, 3) != 0);
            inst_ready_i = ($urandom_range(0, 2) != 0);
            resp_valid_i = mem_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
            resp_data_i  = $urandom;
            resp_err_i   = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
